// File: rtl/cnn_act_pkg.sv
// Shared definitions for the cnn_act_pipe activation pipeline: mode encodings
// and default sizing. The optional counter is enabled by CNN_ACT_SATCNT_EN.
package cnn_act_pkg;

  localparam int WIDTH_DEF = 18;
  localparam int FRAC_DEF  = 8;
  localparam int CH_DEF    = 4;

  typedef enum logic [1:0] {
    MODE_SAT     = 2'b00,
    MODE_PASS    = 2'b01,
    MODE_UNI     = 2'b10,
    MODE_SAT_ALT = 2'b11
  } act_mode_e;

endpackage

// File: rtl/cnn_act_lane.sv
// One channel of the activation datapath: stage 1 registers the absolute
// values and mode, stage 2 registers the clipped sample and its sat flag.
module cnn_act_lane
  import cnn_act_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en1,
  input  logic             en2,
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  // Two guard bits keep |X+ONE| and |X-ONE| exact for every X.
  localparam int W2 = WIDTH + 2;
  localparam logic [W2-1:0] ONE_U = W2'(1) << FRAC;

  function automatic logic [W2-1:0] abs_w(input logic [W2-1:0] v);
    return v[W2-1] ? (~v + W2'(1)) : v;
  endfunction

  logic signed [W2-1:0] xe;
  logic signed [W2-1:0] sum_p;
  logic signed [W2-1:0] sum_n;

  assign xe    = {{2{x[WIDTH-1]}}, x};
  assign sum_p = xe + $signed(ONE_U);
  assign sum_n = xe - $signed(ONE_U);

  logic [W2-1:0]    abs_p_q;
  logic [W2-1:0]    abs_n_q;
  logic [W2-1:0]    abs_x_q;
  logic [WIDTH-1:0] x_q;
  act_mode_e        mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      abs_p_q <= '0;
      abs_n_q <= '0;
      abs_x_q <= '0;
      x_q     <= '0;
      mode_q  <= MODE_SAT;
    end else if (en1) begin
      abs_p_q <= abs_w(sum_p);
      abs_n_q <= abs_w(sum_n);
      abs_x_q <= abs_w(xe);
      x_q     <= x;
      mode_q  <= act_mode_e'(mode);
    end
  end

  // Unipolar clamp uses (|X| - |X-ONE| + ONE) / 2, the one-sided form of the bipolar identity.
  logic signed [W2-1:0] x1e;
  logic signed [W2-1:0] y_full;
  logic                 sat_d;

  assign x1e = {{2{x_q[WIDTH-1]}}, x_q};

  always_comb begin
    y_full = '0;
    case (mode_q)
      MODE_PASS: y_full = x1e;
      MODE_UNI:  y_full = ($signed(abs_x_q) - $signed(abs_n_q) + $signed(ONE_U)) >>> 1;
      default:   y_full = ($signed(abs_p_q) - $signed(abs_n_q)) >>> 1;
    endcase
    sat_d = (y_full != x1e);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (en2) begin
      y   <= y_full[WIDTH-1:0];
      sat <= sat_d;
    end
  end

endmodule

// File: rtl/cnn_act_pipe.sv
// Two-stage CH-lane activation pipeline with valid/ready handshake.
// Defining CNN_ACT_SATCNT_EN adds the sat_cnt saturation event counter.
module cnn_act_pipe
  import cnn_act_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int CH    = CH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*WIDTH-1:0] out_data,
  output logic [CH-1:0]       out_sat
`ifdef CNN_ACT_SATCNT_EN
  ,
  output logic [31:0]         sat_cnt,
  input  logic                sat_cnt_clr
`endif
);

  logic v1;
  logic v2;
  logic adv1;
  logic adv2;
  logic en1;
  logic en2;

  assign adv2     = !v2 || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1 && !rst;
  assign en1      = in_valid && in_ready;
  assign en2      = v1 && adv2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
    end
  end

  logic [CH*WIDTH-1:0] y_all;
  logic [CH-1:0]       sat_all;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    cnn_act_lane #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en1  (en1),
      .en2  (en2),
      .x    (in_data[k*WIDTH +: WIDTH]),
      .mode (in_mode),
      .y    (y_all[k*WIDTH +: WIDTH]),
      .sat  (sat_all[k])
    );
  end

  // Outputs are forced quiet for the whole reset, not just after the first edge.
  assign out_valid = v2 && !rst;
  assign out_data  = rst ? '0 : y_all;
  assign out_sat   = rst ? '0 : sat_all;

`ifdef CNN_ACT_SATCNT_EN
  logic [31:0] cnt_q;
  logic [31:0] pop;
  logic [32:0] cnt_sum;

  always_comb begin
    pop = '0;
    for (int k = 0; k < CH; k++) pop = pop + 32'(out_sat[k]);
    cnt_sum = {1'b0, cnt_q} + {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst || sat_cnt_clr) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end
  end

  assign sat_cnt = rst ? '0 : cnt_q;
`endif

endmodule

// File: tb/tb_cnn_act_pipe.sv
// Self-checking bench for cnn_act_pipe: directed vectors, backpressure, reset
// flush and randomized traffic against a clamp-arithmetic scoreboard.
module tb_cnn_act_pipe;

  localparam int W   = 18;
  localparam int F   = 8;
  localparam int C   = 4;
  localparam int ONE = 256;
  localparam int DW  = C * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [C-1:0]  out_sat;
`ifdef CNN_ACT_SATCNT_EN
  logic [31:0]   sat_cnt;
  logic          sat_cnt_clr;
`endif

  cnn_act_pipe #(.WIDTH(W), .FRAC(F), .CH(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
`ifdef CNN_ACT_SATCNT_EN
    ,
    .sat_cnt     (sat_cnt),
    .sat_cnt_clr (sat_cnt_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [C-1:0]  sat;
    int            acc;
  } beat_t;

  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            n_out    = 0;
  int            last_lat = 0;
  beat_t         exp_q[$];
  logic          s_valid, s_ready, last_xfer;
  logic [DW-1:0] s_data, held_data;
  logic [C-1:0]  s_sat, held_sat;
  logic          stall_prev = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference: plain integer clamps per mode, sat = output differs from input.
  function automatic beat_t model(input logic [DW-1:0] x, input logic [1:0] m, input int acc);
    beat_t b;
    logic signed [W-1:0] xs;
    int xi, yi;
    b.data = '0;
    b.sat  = '0;
    b.acc  = acc;
    for (int k = 0; k < C; k++) begin
      xs = x[k*W +: W];
      xi = xs;
      case (m)
        2'b01:   yi = xi;
        2'b10:   yi = clampi(xi, 0, ONE);
        default: yi = clampi(xi, -ONE, ONE);
      endcase
      b.data[k*W +: W] = W'(yi);
      b.sat[k] = (yi != xi);
    end
    return b;
  endfunction

  function automatic logic [DW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [DW-1:0] r;
    r[0*W +: W] = W'(a);
    r[1*W +: W] = W'(b);
    r[2*W +: W] = W'(c);
    r[3*W +: W] = W'(d);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_sample();
    case ($urandom_range(0, 11))
      0:       return W'(-131072);
      1:       return W'(131071);
      2:       return W'(-257);
      3:       return W'(-256);
      4:       return W'(-255);
      5:       return W'(0);
      6:       return W'(255);
      7:       return W'(256);
      8:       return W'(257);
      9:       return W'($urandom_range(0, 1023)) - W'(512);
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: sample at negedge, score transfers, then step past posedge.
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    s_valid   = out_valid;
    s_data    = out_data;
    s_sat     = out_sat;
    s_ready   = in_ready;
    last_xfer = 1'b0;
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 128'(out_valid), 128'(1));
        chk("hold_data", 128'(out_data), 128'(held_data));
        chk("hold_sat", 128'(out_sat), 128'(held_sat));
      end
      if (out_valid && out_ready) begin
        last_xfer = 1'b1;
        n_out++;
        if (exp_q.size() == 0) begin
          chk("stray_beat", 128'(out_valid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 128'(out_data), 128'(e.data));
          chk("sb_sat", 128'(out_sat), 128'(e.sat));
          last_lat = cyc - e.acc;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode, cyc));
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_sat   = out_sat;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic direct(input string tag, input logic [DW-1:0] x, input logic [1:0] m,
                        input logic [DW-1:0] ey, input logic [C-1:0] es);
    in_valid  = 1'b1;
    in_data   = x;
    in_mode   = m;
    out_ready = 1'b1;
    cycle();
    chk({tag, "_accept"}, 128'(s_ready), 128'(1));
    in_valid = 1'b0;
    in_data  = '0;
    cycle();
    chk({tag, "_early"}, 128'(s_valid), 128'(0));
    cycle();
    chk({tag, "_valid"}, 128'(s_valid), 128'(1));
    chk({tag, "_data"}, 128'(s_data), 128'(ey));
    chk({tag, "_sat"}, 128'(s_sat), 128'(es));
    chk({tag, "_lat"}, 128'(last_lat), 128'(2));
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    chk(tag, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    logic [DW-1:0] x;
    logic [DW-1:0] bp[5];
    int nacc, n0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'b00;
    out_ready = 1'b0;
`ifdef CNN_ACT_SATCNT_EN
    sat_cnt_clr = 1'b0;
`endif
    #1;
    repeat (3) cycle();
    chk("rst_out_valid", 128'(s_valid), 128'(0));
    chk("rst_out_data", 128'(s_data), 128'(0));
    chk("rst_out_sat", 128'(s_sat), 128'(0));
    chk("rst_in_ready", 128'(s_ready), 128'(0));
`ifdef CNN_ACT_SATCNT_EN
    chk("rst_sat_cnt", 128'(sat_cnt), 128'(0));
`endif
    rst = 1'b0;
    cycle();
    chk("ready_after_rst", 128'(s_ready), 128'(1));

    direct("sat_mode", pack4(100, 300, -256, -131072), 2'b00,
           pack4(100, 256, -256, -256), 4'b1010);
    direct("uni_mode", pack4(-50, 0, 131071, 255), 2'b10,
           pack4(0, 0, 256, 255), 4'b0101);
    x = pack4(131071, -131072, int'($urandom_range(0, 4000)) - 2000, -257);
    direct("pass_mode", x, 2'b01, x, 4'b0000);
    direct("mode11", pack4(300, -1000, 5, -5), 2'b11,
           pack4(256, -256, 5, -5), 4'b0011);

    // Backpressure: 5 beats offered back to back, sink stalled for 4 cycles.
    for (int i = 0; i < 5; i++) bp[i] = {rand_sample(), rand_sample(), rand_sample(), rand_sample()};
    n0   = n_out;
    nacc = 0;
    for (int i = 0; i < 12 && nacc < 5; i++) begin
      out_ready = (i >= 4);
      in_valid  = 1'b1;
      in_data   = bp[nacc];
      in_mode   = 2'(nacc % 4);
      cycle();
      if (s_ready) nacc++;
      if (i == 2) begin
        chk("bp_ready_low", 128'(s_ready), 128'(0));
        chk("bp_accepted", 128'(nacc), 128'(2));
      end
    end
    chk("bp_all_accepted", 128'(nacc), 128'(5));
    drain("bp_drain");
    chk("bp_out_count", 128'(n_out - n0), 128'(5));

    // Reset with two beats in flight must discard both.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = pack4(1, 2, 3, 4);
    in_mode   = 2'b01;
    cycle();
    in_data = pack4(5, 6, 7, 8);
    cycle();
    in_valid = 1'b0;
    rst      = 1'b1;
    cycle();
    chk("midrst_out_valid", 128'(s_valid), 128'(0));
    rst       = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("postrst_out_valid", 128'(s_valid), 128'(0));
    chk("postrst_in_ready", 128'(s_ready), 128'(1));
    n0 = n_out;
    repeat (5) cycle();
    chk("postrst_no_stale", 128'(n_out - n0), 128'(0));

    // Randomized traffic with random source gaps and sink stalls.
    n0   = n_out;
    nacc = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      for (int k = 0; k < C; k++) in_data[k*W +: W] = rand_sample();
      cycle();
      if (in_valid && s_ready) nacc++;
    end
    drain("rand_drain");
    chk("rand_out_count", 128'(n_out - n0), 128'(nacc));

`ifdef CNN_ACT_SATCNT_EN
    sat_cnt_clr = 1'b1;
    cycle();
    sat_cnt_clr = 1'b0;
    chk("cnt_cleared", 128'(sat_cnt), 128'(0));
    out_ready = 1'b1;
    in_mode   = 2'b00;
    in_data   = pack4(100, 300, -256, -131072);
    in_valid  = 1'b1;
    repeat (3) cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    chk("cnt_six", 128'(sat_cnt), 128'(6));
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    sat_cnt_clr = 1'b1;
    cycle();
    sat_cnt_clr = 1'b0;
    chk("cnt_clr_xfer", 128'(last_xfer), 128'(1));
    chk("cnt_clr_prio", 128'(sat_cnt), 128'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_act_pipe.md
CNN_ACT_PIPE -- requirements
Module: cnn_act_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 18, giving the signed two's-complement sample width per channel.
REQ-002 The block SHALL have parameter FRAC, default 8, giving the fractional bits, so that ONE = 2**FRAC; it SHALL satisfy FRAC <= WIDTH-2.
REQ-003 The block SHALL have parameter CH, default 4, giving the number of parallel channels.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: a synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-008 The block SHALL have port in_data, input, CH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port in_mode, input, 2 bits: the activation mode, carried with the beat.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream side accepts the beat.
REQ-012 The block SHALL have port out_data, output, CH*WIDTH bits, with the same channel packing as in_data.
REQ-013 The block SHALL have port out_sat, output, CH bits: bit k is 1 when channel k was clipped.
REQ-014 The block SHALL have port sat_cnt, output, 32 bits, present only under the configuration macro: the saturation event count.
REQ-015 The block SHALL have port sat_cnt_clr, input, 1 bit, present only under the configuration macro: a synchronous clear of sat_cnt.

Function
REQ-016 A beat SHALL transfer at the input when in_valid && in_ready, and at the output when out_valid && out_ready.
REQ-017 Mode 00 SHALL compute Y = (|X+ONE| - |X-ONE|) >>> 1, which is exactly clamp(X, -ONE, +ONE).
REQ-018 Mode 01 SHALL pass the sample through unchanged (Y = X), with out_sat = 0.
REQ-019 Mode 10 SHALL compute Y = clamp(X, 0, +ONE).
REQ-020 Mode 11 SHALL behave as mode 00.
REQ-021 out_sat[k] SHALL be 1 if and only if Y differs from X for channel k.
REQ-022 Intermediate sums and absolute values SHALL be computed at WIDTH+2 bits, so that no overflow occurs for any X, including the most negative and most positive values; Y SHALL be truncated back to WIDTH bits, which is lossless.
REQ-023 The pipeline SHALL have 2 register stages: stage 1 holds the absolute values and the mode; stage 2 holds Y and out_sat.
REQ-024 Latency SHALL be exactly 2 cycles from input acceptance to out_valid when there is no backpressure.
REQ-025 Throughput SHALL be 1 beat per cycle while out_ready = 1.
REQ-026 Stage-advance rules SHALL be:
- adv2 = !v2 || out_ready
- adv1 = !v1 || adv2
- in_ready = adv1
REQ-027 in_ready SHALL NOT depend combinationally on in_valid.
REQ-028 Under backpressure the pipeline SHALL hold at most 2 beats, drop none, and preserve their order.
REQ-029 out_data and out_sat SHALL remain stable while out_valid && !out_ready.
REQ-030 An acceptance at the input and a transfer at the output in the same cycle SHALL both take effect.

Reset
REQ-031 While rst = 1, the block SHALL clear both stage-valid flags, so that out_valid = 0.
REQ-032 While rst = 1, the block SHALL drive out_data = 0 and out_sat = 0.
REQ-033 While rst = 1, the block SHALL hold sat_cnt = 0 and in_ready = 0.
REQ-034 On the cycle after rst falls, in_ready SHALL be 1.
REQ-035 A reset asserted mid-stream SHALL discard all in-flight beats, and none of them SHALL appear at the output.

Configuration
REQ-036 The macro CNN_ACT_SATCNT_EN, when defined, SHALL compile in sat_cnt and sat_cnt_clr.
REQ-037 With CNN_ACT_SATCNT_EN defined, sat_cnt SHALL add popcount(out_sat) on each output transfer and saturate at 2**32-1.
REQ-038 With CNN_ACT_SATCNT_EN defined, sat_cnt_clr SHALL take priority over an increment in the same cycle, and sat_cnt SHALL read 0 on the next cycle.
REQ-039 With CNN_ACT_SATCNT_EN undefined, the ports sat_cnt and sat_cnt_clr and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-040 The package cnn_act_pkg SHALL hold the mode encodings (MODE_SAT, MODE_PASS, MODE_UNI) and the default WIDTH, FRAC and CH constants.
REQ-041 The sub-module cnn_act_lane SHALL implement one channel's stage-1 and stage-2 arithmetic and sat flag, instantiated CH times.
REQ-042 The handshake and valid flags SHALL live only in cnn_act_pipe.

Verification (WIDTH=18, FRAC=8, ONE=256, CH=4)
REQ-043 The bench SHALL drive mode 00 with ch0..3 = 100, 300, -256, -131072 and out_ready=1, and SHALL check out_data = 100, 256, -256, -256 and out_sat = 4'b1010, with out_valid exactly 2 cycles after acceptance.
REQ-044 The bench SHALL drive mode 10 with ch0..3 = -50, 0, 131071, 255, and SHALL check out_data = 0, 0, 256, 255 and out_sat = 4'b0101.
REQ-045 The bench SHALL drive mode 01 with ch0 = 131071 and ch1 = -131072, and SHALL check the output equals the input and out_sat = 0.
REQ-046 The bench SHALL stream 5 consecutive beats while holding out_ready=0 for 4 cycles, and SHALL check that in_ready falls after 2 beats are accepted, that the output is held stable, and that all 5 beats emerge in order with no loss or duplication.
REQ-047 The bench SHALL assert rst for 1 cycle with 2 beats in flight, and SHALL check out_valid=0 the next cycle and that no stale beat appears afterwards.
REQ-048 With CNN_ACT_SATCNT_EN defined, the bench SHALL send the REQ-043 beat 3 times and check sat_cnt=6, then pulse sat_cnt_clr coincident with a 4th transfer and check sat_cnt=0.
